// File: rtl/soc_bus_fabric.sv
// CPU-to-slave bus fabric: page decode, one-cycle strobes, wait-state
// handshake with timeout to a one-cycle bus error and a saturating error count.
module soc_bus_fabric #(
  parameter int              NSLV      = 6,
  parameter logic [15:0]     BASE_PAGE = 16'h0040,
  parameter logic [NSLV-1:0] ZW_MASK   = {{(NSLV-1){1'b0}}, 1'b1},
  parameter int              TIMEOUT   = 15,
  parameter logic [31:0]     ERR_DATA  = 32'h66666666
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wmask,
  input  logic               mem_rstrb,
  output logic [31:0]        mem_rdata,
  output logic               mem_rbusy,
  output logic               mem_wbusy,
  output logic [NSLV-1:0]    s_cs,
  output logic               s_rd,
  output logic               s_wr,
  output logic [3:0]         s_wmask,
  output logic [31:0]        s_wdata,
  output logic [31:0]        s_addr,
  input  logic [NSLV*32-1:0] s_rdata,
  input  logic [NSLV-1:0]    s_ready,
  output logic               bus_err,
  output logic [7:0]         err_count
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t          state_q;
  logic [IW-1:0]   sel_q;
  logic            op_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      err_q;

  logic [NSLV-1:0] page_match;
  logic [IW-1:0]   dec_idx;
  logic            req;
  logic            is_wr;
  logic            fast;

  assign page_match[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NSLV; gi++) begin : g_dec
      assign page_match[gi] = (mem_addr[31:16] == BASE_PAGE + 16'(gi - 1));
    end
  endgenerate

  always_comb begin
    dec_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (page_match[i]) dec_idx = IW'(i);
    end
  end

  assign is_wr     = |mem_wmask;
  assign req       = resetn && (state_q == IDLE) && (mem_rstrb || is_wr);
  assign fast      = ZW_MASK[dec_idx] || s_ready[dec_idx];
  assign s_addr    = mem_addr;
  assign s_wdata   = mem_wdata;
  assign err_count = err_q;

  always_comb begin
    s_cs      = '0;
    s_rd      = 1'b0;
    s_wr      = 1'b0;
    s_wmask   = 4'b0;
    mem_rbusy = 1'b0;
    mem_wbusy = 1'b0;
    bus_err   = 1'b0;
    mem_rdata = s_rdata[31:0];
    case (state_q)
      IDLE: if (req) begin
        s_cs      = NSLV'(1) << dec_idx;
        s_rd      = mem_rstrb && !is_wr;
        s_wr      = is_wr;
        s_wmask   = mem_wmask;
        mem_rdata = s_rdata[32*dec_idx +: 32];
        mem_rbusy = !fast && !is_wr;
        mem_wbusy = !fast && is_wr;
      end
      WAIT: begin
        s_cs      = NSLV'(1) << sel_q;
        mem_rdata = s_rdata[32*sel_q +: 32];
        // busy falls in the same cycle the slave reports ready
        mem_rbusy = resetn && !s_ready[sel_q] && !op_q;
        mem_wbusy = resetn && !s_ready[sel_q] && op_q;
      end
      ERR: begin
        mem_rdata = ERR_DATA;
        bus_err   = resetn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req) begin
            sel_q <= dec_idx;
            op_q  <= is_wr;
            if (!fast) state_q <= WAIT;
          end
        end
        WAIT: begin
          if (s_ready[sel_q]) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= ERR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ERR: begin
          state_q <= IDLE;
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: directed scenarios plus randomized
// transactions checked against a per-transaction timing model.
module tb_soc_bus_fabric;
  localparam int TO = 15;
  localparam logic [31:0] EDATA = 32'h66666666;

  logic         clk, resetn;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata, s_wdata, s_addr;
  logic [3:0]   mem_wmask, s_wmask;
  logic         mem_rstrb, mem_rbusy, mem_wbusy, s_rd, s_wr, bus_err;
  logic [5:0]   s_cs, s_ready;
  logic [191:0] s_rdata;
  logic [7:0]   err_count;
  logic [31:0]  sd [6];

  int errors = 0;
  int checks = 0;
  int err_exp = 0;

  soc_bus_fabric dut (
    .clk(clk), .resetn(resetn),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
    .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr), .s_wmask(s_wmask),
    .s_wdata(s_wdata), .s_addr(s_addr), .s_rdata(s_rdata), .s_ready(s_ready),
    .bus_err(bus_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < 6; i++) s_rdata[32*i +: 32] = sd[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_data();
    for (int i = 0; i < 6; i++) sd[i] = $urandom;
  endtask

  task automatic idle_inputs();
    mem_rstrb = 1'b0;
    mem_wmask = 4'h0;
    s_ready   = 6'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_addr = 32'h0041_0000; mem_wdata = 32'h1234_5678;
    mem_rstrb = 1'b1; mem_wmask = 4'hF; s_ready = 6'h0; new_data();
    repeat (2) step();
    @(negedge clk);
    checks++;
    if ({mem_rbusy, mem_wbusy, s_rd, s_wr, s_wmask, bus_err} !== 9'b0)
      begin errors++; $display("FAIL reset_outputs got=%b want=0", {mem_rbusy, mem_wbusy, s_rd, s_wr, s_wmask, bus_err}); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
    step();
    idle_inputs(); resetn = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_zero_wait_read();
    new_data();
    mem_addr = 32'h0000_0010; mem_rstrb = 1'b1; mem_wmask = 4'h0;
    @(negedge clk);
    checks++;
    if ({s_cs, s_rd, s_wr, mem_rbusy} !== {6'b000001, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL zw_strobe got cs=%b rd=%b wr=%b rbusy=%b want cs=000001 rd=1 wr=0 rbusy=0", s_cs, s_rd, s_wr, mem_rbusy); end
    checks++;
    if (mem_rdata !== sd[0]) begin errors++; $display("FAIL zw_rdata got=%h want=%h", mem_rdata, sd[0]); end
    checks++;
    if (s_addr !== 32'h10) begin errors++; $display("FAIL zw_addr got=%h want=00000010", s_addr); end
    step(); idle_inputs();
    @(negedge clk);
    checks++;
    if ({s_rd, mem_rbusy, s_cs} !== 8'b0) begin errors++; $display("FAIL zw_after got rd=%b rbusy=%b cs=%b want 0", s_rd, mem_rbusy, s_cs); end
    step();
    $display("test_zero_wait_read done");
  endtask

  task automatic test_wait_write();
    new_data();
    mem_addr = 32'h0042_0000; mem_wmask = 4'b0001; mem_rstrb = 1'b0; s_ready = 6'h0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) mem_wmask = 4'h0;
      s_ready[3] = (k == 3);
      @(negedge clk);
      checks++;
      if ({s_cs, s_wr, mem_wbusy, mem_rbusy} !== {((k < 4) ? 6'b001000 : 6'b0), (k == 0), (k < 3), 1'b0})
        begin errors++; $display("FAIL wait_write cycle=%0d got cs=%b wr=%b wbusy=%b rbusy=%b", k, s_cs, s_wr, mem_wbusy, mem_rbusy); end
      if (k == 3) begin
        checks++;
        if (mem_rdata !== sd[3]) begin errors++; $display("FAIL wait_write_rdata got=%h want=%h", mem_rdata, sd[3]); end
      end
      step();
    end
    idle_inputs();
    $display("test_wait_write done");
  endtask

  task automatic test_timeout();
    int busy_n = 0, pulses = 0;
    logic [31:0] rd_err = 32'h0;
    new_data();
    mem_addr = 32'h0041_0004; mem_rstrb = 1'b1; mem_wmask = 4'h0; s_ready = 6'h0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) mem_rstrb = 1'b0;
      @(negedge clk);
      if (mem_rbusy) busy_n++;
      if (bus_err) begin pulses++; rd_err = mem_rdata; end
      step();
    end
    err_exp = 1;
    checks++;
    if (busy_n != TO + 1) begin errors++; $display("FAIL timeout_busy got=%0d want=%0d", busy_n, TO + 1); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got=%0d want=1", pulses); end
    checks++;
    if (rd_err !== EDATA) begin errors++; $display("FAIL timeout_rdata got=%h want=%h", rd_err, EDATA); end
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_errcnt got=%0d want=1", err_count); end
    $display("test_timeout done");
  endtask

  task automatic test_write_priority();
    new_data();
    mem_addr = 32'h0041_0000; mem_rstrb = 1'b1; mem_wmask = 4'hF; s_ready = 6'h0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin mem_rstrb = 1'b0; mem_wmask = 4'h0; end
      s_ready[2] = (k == 2);
      @(negedge clk);
      checks++;
      if ({s_rd, s_wr, mem_wbusy, mem_rbusy} !== {1'b0, (k == 0), (k < 2), 1'b0})
        begin errors++; $display("FAIL priority cycle=%0d got rd=%b wr=%b wbusy=%b rbusy=%b", k, s_rd, s_wr, mem_wbusy, mem_rbusy); end
      step();
    end
    idle_inputs();
    $display("test_write_priority done");
  endtask

  task automatic test_reset_mid_wait();
    new_data();
    mem_addr = 32'h0043_0000; mem_rstrb = 1'b1; mem_wmask = 4'h0; s_ready = 6'h0;
    step(); mem_rstrb = 1'b0;
    step(); resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_rbusy, bus_err} !== 2'b00) begin errors++; $display("FAIL rst_wait_during got rbusy=%b err=%b want 00", mem_rbusy, bus_err); end
    step(); resetn = 1'b1;
    err_exp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_rbusy, mem_wbusy, bus_err, s_cs} !== 9'b0 || err_count !== 8'd0)
        begin errors++; $display("FAIL rst_wait_after cycle=%0d got busy=%b%b err=%b cs=%b cnt=%0d", k, mem_rbusy, mem_wbusy, bus_err, s_cs, err_count); end
      step();
    end
    $display("test_reset_mid_wait done");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int slave, delay, op, c, nbusy;
      bit wr, tmo;
      logic [15:0] pg;
      logic [3:0] msk;
      slave = $urandom_range(0, 5);
      op    = $urandom_range(0, 2);
      delay = $urandom_range(0, TO + 2);
      wr    = (op != 0);
      msk   = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      tmo   = (slave != 0) && (delay > TO);
      nbusy = (slave == 0) ? 0 : (tmo ? TO + 1 : delay);
      c     = (slave == 0) ? 0 : (tmo ? TO + 1 : delay);
      pg = 16'($urandom);
      if (slave != 0) pg = 16'h0040 + 16'(slave - 1);
      else if (pg >= 16'h0040 && pg <= 16'h0044) pg = pg ^ 16'h8000;
      new_data();
      mem_addr = {pg, 16'($urandom)}; mem_wdata = $urandom;
      for (int k = 0; k <= c; k++) begin
        logic [5:0] ecs;
        logic [31:0] erd;
        bit eerr;
        if (k == 0) begin
          mem_rstrb = (op != 1); mem_wmask = msk;
        end else begin
          mem_rstrb = 1'($urandom); mem_wmask = 4'($urandom);
        end
        s_ready = 6'($urandom);
        if (slave != 0) s_ready[slave] = !tmo && (k == delay);
        eerr = tmo && (k == c);
        ecs  = eerr ? 6'b0 : (6'b1 << slave);
        erd  = eerr ? EDATA : sd[slave];
        @(negedge clk);
        checks++;
        if ({s_cs, s_rd, s_wr, s_wmask} !== {ecs, (k == 0) && !wr, (k == 0) && wr, (k == 0) ? msk : 4'h0})
          begin errors++; $display("FAIL rnd_strobe t=%0d k=%0d got cs=%b rd=%b wr=%b m=%h", t, k, s_cs, s_rd, s_wr, s_wmask); end
        checks++;
        if ({mem_rbusy, mem_wbusy} !== {(k < nbusy) && !wr, (k < nbusy) && wr})
          begin errors++; $display("FAIL rnd_busy t=%0d k=%0d got r=%b w=%b want busy=%0d wr=%0d", t, k, mem_rbusy, mem_wbusy, k < nbusy, wr); end
        checks++;
        if (mem_rdata !== erd) begin errors++; $display("FAIL rnd_rdata t=%0d k=%0d got=%h want=%h", t, k, mem_rdata, erd); end
        checks++;
        if (bus_err !== eerr) begin errors++; $display("FAIL rnd_buserr t=%0d k=%0d got=%b want=%b", t, k, bus_err, eerr); end
        step();
      end
      if (tmo && err_exp < 255) err_exp++;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (s_cs !== 6'b0 || mem_rdata !== sd[0] || err_count !== 8'(err_exp))
        begin errors++; $display("FAIL rnd_idle t=%0d got cs=%b rd=%h cnt=%0d want cs=0 rd=%h cnt=%0d", t, s_cs, mem_rdata, err_count, sd[0], err_exp); end
      step();
      $display("rnd txn %0d slave=%0d wr=%0d delay=%0d timeout=%0d", t, slave, wr, delay, tmo);
    end
  endtask

  task automatic test_saturation();
    resetn = 1'b0; idle_inputs(); step(); resetn = 1'b1; step();
    for (int n = 1; n <= 256; n++) begin
      bit seen = 0;
      mem_addr = 32'h0044_0000; mem_rstrb = 1'b1; mem_wmask = 4'h0; s_ready = 6'h0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (bus_err) seen = 1;
        step();
        mem_rstrb = 1'b0;
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL sat_no_buserr n=%0d", n);
      end
      if (n == 255 || n == 256) begin
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL sat_errcnt n=%0d got=%0d want=255", n, err_count); end
      end
    end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_write_priority();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
